// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch front end.
// Issues word reads to instruction memory, parks each request in a circular
// slot queue tagged with its PC, fills slots as responses return in order,
// and hands filled slots to decode over a valid/ready handshake. A redirect
// from execute flushes the queue and remembers how many responses of the old
// stream are still owed so they can be discarded when they arrive.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemRvalid,
    input  logic [XLEN-1:0] ImemRdata,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            InstrValid,
    input  logic            InstrReady,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    localparam int PW = $clog2(DEPTH);   // pointer width
    localparam int CW = PW + 1;          // counter width, holds 0..DEPTH

    localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(DEPTH);

    // Fetch state
    logic [XLEN-1:0] pcf;
    logic [PW-1:0]   head;
    logic [PW-1:0]   fill;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   alloc;   // slots allocated
    logic [CW-1:0]   owed;    // allocated slots still waiting for data
    logic [CW-1:0]   drop;    // stale responses still to be discarded

    // Slot array; the filled flags are control state, the payload is data
    logic [DEPTH-1:0] filled;
    logic [XLEN-1:0]  slot_pc    [DEPTH];
    logic [XLEN-1:0]  slot_instr [DEPTH];

    // Last presented head, shown while the queue is empty
    logic [XLEN-1:0] held_pc;
    logic [XLEN-1:0] held_instr;

    logic issue;
    logic rsp_keep;
    logic rsp_drop;
    logic head_valid;
    logic deq;

    // Low address bits of the redirect target are ignored by design.
    logic unused_target_bits;
    assign unused_target_bits = &{1'b0, PCTarget[1:0]};

    // Space is reserved for stale responses too, so a full queue plus the
    // owed old-stream responses never exceeds DEPTH outstanding reads.
    assign issue      = !PCSrc && (({1'b0, alloc} + {1'b0, drop}) < DEPTH_SUM);
    assign rsp_keep   = ImemRvalid && !PCSrc && (drop == '0);
    assign rsp_drop   = ImemRvalid && !rsp_keep;
    assign head_valid = (alloc != '0) && filled[head];
    assign deq        = head_valid && InstrReady && !PCSrc;

    assign ImemReq    = issue;
    assign ImemAddr   = pcf;
    assign InstrValid = head_valid;
    assign InstrD     = head_valid ? slot_instr[head] : held_instr;
    assign PCD        = head_valid ? slot_pc[head]    : held_pc;
    assign PCPlus4D   = PCD + XLEN'(4);

    // Control state: PC, pointers, occupancy counters and slot filled flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcf    <= RESET_PC;
            head   <= '0;
            fill   <= '0;
            tail   <= '0;
            alloc  <= '0;
            owed   <= '0;
            drop   <= '0;
            filled <= '0;
        end else if (PCSrc) begin
            // Flush: every unfilled slot turns into a response to discard;
            // a response arriving this cycle settles one of them already.
            pcf   <= {PCTarget[XLEN-1:2], 2'b00};
            head  <= tail;
            fill  <= tail;
            alloc <= '0;
            owed  <= '0;
            drop  <= drop + owed - CW'(ImemRvalid);
        end else begin
            if (issue) begin
                pcf          <= pcf + XLEN'(4);
                tail         <= tail + PW'(1);
                filled[tail] <= 1'b0;
            end
            if (rsp_keep) begin
                filled[fill] <= 1'b1;
                fill         <= fill + PW'(1);
            end
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            alloc <= alloc + CW'(issue) - CW'(deq);
            owed  <= owed + CW'(issue) - CW'(rsp_keep);
        end
    end

    // Slot payload: PC written at issue, instruction written at response.
    // NOTE: the payload array is not reset; a slot is only ever read once its
    // filled flag (which is reset) says it holds data, so clearing it buys
    // nothing but reset fan-out.
    always_ff @(posedge clk) begin
        if (issue) begin
            slot_pc[tail] <= pcf;
        end
        if (rsp_keep) begin
            slot_instr[fill] <= ImemRdata;
        end
    end

    // Remember the presented head so the outputs hold while the queue is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held_pc    <= '0;
            held_instr <= '0;
        end else if (head_valid) begin
            held_pc    <= slot_pc[head];
            held_instr <= slot_instr[head];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a latency-programmable
// in-order memory model. A second instance checks PC wrap-around.
module tb_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    // Wrap-around instance signals
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_pcsrc;
    logic [31:0] w_target;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [31:0] w_pcd;
    logic [31:0] w_pc4;

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0100)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemRvalid (ImemRvalid),
        .ImemRdata  (ImemRdata),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D)
    );

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk        (clk),
        .reset_n    (reset_n),
        .ImemReq    (w_req),
        .ImemAddr   (w_addr),
        .ImemRvalid (w_rvalid),
        .ImemRdata  (w_rdata),
        .PCSrc      (w_pcsrc),
        .PCTarget   (w_target),
        .InstrValid (w_valid),
        .InstrReady (w_ready),
        .InstrD     (w_instr),
        .PCD        (w_pcd),
        .PCPlus4D   (w_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    typedef struct {
        bit          ready;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pcd;
    } vec_t;
    vec_t vq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Finish the current cycle: sample requests, clock, then drive the
    // memory responses due in the new cycle.
    task automatic tick();
        logic        req;
        logic        rv;
        logic        wreq;
        logic [31:0] a;
        logic [31:0] wa;
        #1;
        req  = ImemReq;
        a    = ImemAddr;
        rv   = ImemRvalid;
        wreq = w_req;
        wa   = w_addr;
        assert (!(rv && mq.size() == 0)) else $error("response with no outstanding request");
        @(posedge clk);
        #1;
        cyc++;
        if (rv) void'(mq.pop_front());
        if (req) mq.push_back('{addr: a, due: cyc - 1 + lat});
        if (mq.size() > 0 && mq[0].due == cyc) begin
            ImemRvalid = 1'b1;
            ImemRdata  = mem_word(mq[0].addr);
        end else begin
            ImemRvalid = 1'b0;
            ImemRdata  = '0;
        end
        w_rvalid = wreq;
        w_rdata  = mem_word(wa);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        mq.delete();
        ImemRvalid = 1'b0;
        ImemRdata  = '0;
        w_rvalid   = 1'b0;
        w_rdata    = '0;
        PCSrc      = 1'b0;
        PCTarget   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic add(input bit rdy, input bit req, input logic [31:0] addr,
                       input bit vld, input logic [31:0] pcd);
        vq.push_back('{ready: rdy, req: req, addr: addr, valid: vld, pcd: pcd});
    endtask

    initial begin
        bit found;

        reset_n    = 1'b0;
        InstrReady = 1'b1;
        w_ready    = 1'b1;
        w_pcsrc    = 1'b0;
        w_target   = '0;

        // Stream with 1-cycle memory, cycles 0..5
        add(1, 1, 32'h100, 0, 32'h0);
        add(1, 1, 32'h104, 0, 32'h0);
        add(1, 1, 32'h108, 1, 32'h100);
        add(1, 1, 32'h10C, 1, 32'h104);
        add(1, 1, 32'h110, 1, 32'h108);
        add(1, 1, 32'h114, 1, 32'h10C);
        // Backpressure after a fresh reset: 10 stalled cycles, then drain
        add(0, 1, 32'h100, 0, 32'h0);
        add(0, 1, 32'h104, 0, 32'h0);
        add(0, 1, 32'h108, 1, 32'h100);
        add(0, 1, 32'h10C, 1, 32'h100);
        for (int i = 0; i < 6; i++) add(0, 0, 32'h0, 1, 32'h100);
        add(1, 0, 32'h0,   1, 32'h100);
        add(1, 1, 32'h110, 1, 32'h104);
        add(1, 1, 32'h114, 1, 32'h108);
        add(1, 1, 32'h118, 1, 32'h10C);
        add(1, 1, 32'h11C, 1, 32'h110);

        // Reset state
        lat = 1;
        do_reset();
        check("rst_valid",  32'(InstrValid), 32'd1 - 32'd1);
        check("rst_instr",  InstrD,   32'h0);
        check("rst_pcd",    PCD,      32'h0);
        check("rst_pc4",    PCPlus4D, 32'h4);
        check("rst_req",    32'(ImemReq), 32'd1);
        check("rst_addr",   ImemAddr, 32'h100);

        foreach (vq[i]) begin
            if (i == 6) do_reset();
            InstrReady = vq[i].ready;
            #1;
            check($sformatf("vec%0d_req", i), 32'(ImemReq), 32'(vq[i].req));
            if (vq[i].req) check($sformatf("vec%0d_addr", i), ImemAddr, vq[i].addr);
            check($sformatf("vec%0d_valid", i), 32'(InstrValid), 32'(vq[i].valid));
            if (vq[i].valid) begin
                check($sformatf("vec%0d_pcd", i),   PCD,      vq[i].pcd);
                check($sformatf("vec%0d_pc4", i),   PCPlus4D, vq[i].pcd + 32'h4);
                check($sformatf("vec%0d_instr", i), InstrD,   mem_word(vq[i].pcd));
            end
            tick();
        end

        // Wrap-around instance, 1-cycle memory
        do_reset();
        InstrReady = 1'b1;
        #1;
        check("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr2", w_addr, 32'h0000_0000);
        check("wrap_pcd0",  w_pcd,  32'hFFFF_FFF8);
        check("wrap_v0",    32'(w_valid), 32'd1);
        tick();
        check("wrap_pcd1",  w_pcd,  32'hFFFF_FFFC);
        check("wrap_pc4_1", w_pc4,  32'h0000_0000);
        check("wrap_v1",    32'(w_valid), 32'd1);
        tick();

        // Redirect with three responses in flight, 3-cycle memory
        lat = 3;
        do_reset();
        InstrReady = 1'b1;
        repeat (3) tick();
        #1;
        check("rd3_stale_arrives", 32'(ImemRvalid), 32'd1);
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_2002;
        #1;
        check("rd3_noreq_in_redirect", 32'(ImemReq), 32'd0);
        tick();
        PCSrc = 1'b0;
        #1;
        check("rd3_req",   32'(ImemReq), 32'd1);
        check("rd3_addr",  ImemAddr, 32'h0000_2000);
        for (int k = 4; k < 8; k++) begin
            #1;
            check($sformatf("rd3_novalid_c%0d", k), 32'(InstrValid), 32'd0);
            tick();
        end
        #1;
        check("rd3_first_valid", 32'(InstrValid), 32'd1);
        check("rd3_first_pcd",   PCD,    32'h0000_2000);
        check("rd3_first_instr", InstrD, mem_word(32'h0000_2000));
        tick();

        // Redirect in the same cycle as a dequeue, 1-cycle memory
        lat = 1;
        do_reset();
        InstrReady = 1'b1;
        repeat (3) tick();
        #1;
        check("rdq_pre_valid", 32'(InstrValid), 32'd1);
        check("rdq_pre_pcd",   PCD, 32'h104);
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_3000;
        tick();
        PCSrc = 1'b0;
        #1;
        check("rdq_valid_after", 32'(InstrValid), 32'd0);
        check("rdq_addr",        ImemAddr, 32'h0000_3000);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            #1;
            if (InstrValid) begin
                found = 1'b1;
                check("rdq_first_pcd", PCD, 32'h0000_3000);
                check("rdq_first_cyc", 32'(cyc), 32'd6);
            end else begin
                tick();
            end
        end
        check("rdq_found", 32'(found), 32'd1);

        // Asynchronous reset with the queue three-quarters full
        do_reset();
        InstrReady = 1'b0;
        repeat (3) tick();
        #1;
        check("mid_pre_valid", 32'(InstrValid), 32'd1);
        check("mid_pre_addr",  ImemAddr, 32'h10C);
        reset_n = 1'b0;
        #1;
        check("mid_valid", 32'(InstrValid), 32'd0);
        check("mid_pcf",   ImemAddr, 32'h100);
        check("mid_pcd",   PCD, 32'h0);
        do_reset();
        #1;
        check("mid_after_addr", ImemAddr, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
